// File: rtl/onehot_strobe_dec.sv
// rtl/onehot_strobe_dec.sv - index+hold to registered one-hot strobe with a zero guard cycle
// Optional one-entry request buffer: ONEHOT_STROBE_DEC_BUF_EN
module onehot_strobe_dec #(
    parameter int IDX_W  = 2,
    parameter int HOLD_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic [HOLD_W-1:0]       in_hold,
    output logic [(1<<IDX_W)-1:0]   y,
    output logic                    busy,
    output logic                    done
);

    localparam int OUT_W = 1 << IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]  y_q, y_d;
    logic              accept;

`ifdef ONEHOT_STROBE_DEC_BUF_EN
    logic              pend_valid_q, pend_valid_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [HOLD_W-1:0] pend_hold_q, pend_hold_d;

    assign in_ready = !pend_valid_q;
    assign busy     = (state_q != S_IDLE) || pend_valid_q;
`else
    assign in_ready = (state_q != S_DRIVE);
    assign busy     = (state_q != S_IDLE);
`endif

    assign accept = in_valid && in_ready;
    assign done   = (state_q == S_DRIVE) && (cnt_q == '0);
    assign y      = y_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef ONEHOT_STROBE_DEC_BUF_EN
        pend_valid_d = pend_valid_q;
        pend_idx_d   = pend_idx_q;
        pend_hold_d  = pend_hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d   = in_idx;
                    cnt_d   = in_hold;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_GAP;
                end
`ifdef ONEHOT_STROBE_DEC_BUF_EN
                if (accept) begin
                    pend_valid_d = 1'b1;
                    pend_idx_d   = in_idx;
                    pend_hold_d  = in_hold;
                end
`endif
            end
            S_GAP: begin
`ifdef ONEHOT_STROBE_DEC_BUF_EN
                // A parked request wins; in_ready is low so nothing new can race it.
                if (pend_valid_q) begin
                    idx_d        = pend_idx_q;
                    cnt_d        = pend_hold_q;
                    pend_valid_d = 1'b0;
                    state_d      = S_DRIVE;
                end else
`endif
                if (accept) begin
                    idx_d   = in_idx;
                    cnt_d   = in_hold;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobe is decoded from next state so y leaves a flop with no output logic.
        y_d = '0;
        if (state_d == S_DRIVE) begin
            y_d = {{(OUT_W-1){1'b0}}, 1'b1} << idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
`ifdef ONEHOT_STROBE_DEC_BUF_EN
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            pend_hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
`ifdef ONEHOT_STROBE_DEC_BUF_EN
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            pend_hold_q  <= pend_hold_d;
`endif
        end
    end

endmodule

// File: tb/tb_onehot_strobe_dec.sv
// tb/tb_onehot_strobe_dec.sv - scoreboard bench for onehot_strobe_dec
module tb_onehot_strobe_dec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic [3:0] in_hold;
    logic [3:0] y;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

`ifdef ONEHOT_STROBE_DEC_BUF_EN
    localparam bit RDY_DRV = 1'b1;
`else
    localparam bit RDY_DRV = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] y;
        logic       done;
        logic       ready;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    onehot_strobe_dec #(.IDX_W(2), .HOLD_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .in_hold  (in_hold),
        .y        (y),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] ey, input logic ed, input logic er, input logic eb);
        exp_t e;
        e.y = ey; e.done = ed; e.ready = er; e.busy = eb;
        exp_q.push_back(e);
    endtask

    task automatic push_strobe(input int idx, input int hold);
        logic [3:0] one;
        one = 4'b0001 << idx;
        for (int i = 0; i <= hold; i++) push(one, (i == hold), RDY_DRV, 1'b1);
    endtask

    // One entry per rising edge, compared shortly after that edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("y", 32'(y), 32'(mon_e.y));
            check("done", 32'(done), 32'(mon_e.done));
            check("in_ready", 32'(in_ready), 32'(mon_e.ready));
            check("busy", 32'(busy), 32'(mon_e.busy));
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic send(input int idx, input int hold);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_idx   = 2'(idx);
        in_hold  = 4'(hold);
        push_strobe(idx, hold);
        push(4'b0000, 1'b0, 1'b1, 1'b1);
        push(4'b0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_idx   = '0;
        in_hold  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_y", 32'(y), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        send(2, 0);
        send(3, 3);
        send(0, 15);

`ifndef ONEHOT_STROBE_DEC_BUF_EN
        // back-to-back: second request taken in the guard cycle
        in_valid = 1'b1; in_idx = 2'd0; in_hold = 4'd1;
        push_strobe(0, 1);
        push(4'b0000, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_idx = 2'd1;
        push_strobe(1, 1);
        push(4'b0000, 1'b0, 1'b1, 1'b1);
        push(4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // request presented only while in_ready=0 must be ignored
        in_valid = 1'b1; in_idx = 2'd1; in_hold = 4'd3;
        push_strobe(1, 3);
        push(4'b0000, 1'b0, 1'b1, 1'b1);
        repeat (3) push(4'b0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_idx = 2'd2;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
`else
        // second request parks in the pending slot during DRIVE
        in_valid = 1'b1; in_idx = 2'd1; in_hold = 4'd2;
        push(4'b0010, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_idx = 2'd3; in_hold = 4'd0;
        push(4'b0010, 1'b0, 1'b0, 1'b1);
        push(4'b0010, 1'b1, 1'b0, 1'b1);
        push(4'b0000, 1'b0, 1'b0, 1'b1);
        push(4'b1000, 1'b1, 1'b1, 1'b1);
        push(4'b0000, 1'b0, 1'b1, 1'b1);
        push(4'b0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
`endif

        // asynchronous reset in the middle of a long strobe
        in_valid = 1'b1; in_idx = 2'd1; in_hold = 4'd7;
        push_strobe(1, 2);
        exp_q[2].done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_y", 32'(y), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_y", 32'(y), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end

        send(1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
